alu_issue_stage: RTL

Registered issue stage between decode and the ALU in the RISC-V pipeline. Accepts one decoded instruction per cycle over a valid/ready handshake, translates opcode/funct3/funct7 into the 4-bit ALU control code, selects both ALU operands, and presents them with a one-cycle latency. A two-entry skid buffer absorbs downstream back-pressure, and a flush input squashes in-flight instructions on branch redirect.

---
 rtl/alu_issue_stage.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// ============================================================================
// alu_issue_stage: decode-to-ALU issue register with optional skid buffer.
// Optional feature macro: ALU_ISSUE_SKID_EN (two-entry skid, registered ready)
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [3:0]      alu_ctrl,
    output logic [4:0]      rd_out,
    output logic            illegal
);

    localparam logic [3:0] c_ALU_ADD  = 4'b0010;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;
    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_SLL  = 4'b1000;
    localparam logic [3:0] c_ALU_SRL  = 4'b1001;
    localparam logic [3:0] c_ALU_SRA  = 4'b1011;
    localparam logic [3:0] c_ALU_BEQ  = 4'b1100;
    localparam logic [3:0] c_ALU_BNE  = 4'b1101;
    localparam logic [3:0] c_ALU_BGE  = 4'b1110;
    localparam logic [3:0] c_ALU_BLT  = 4'b1111;
    localparam logic [3:0] c_ALU_NONE = 4'b0111;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    // Entry layout: {illegal, ctrl, rd, in1, in2}
    localparam int c_EW = 2 * XLEN + 10;

    logic            w_ok;
    logic [3:0]      w_ctrl;
    logic [XLEN-1:0] w_in1;
    logic [XLEN-1:0] w_in2;
    logic [c_EW-1:0] w_dec;
    logic            w_in_xfer;

    logic            r_main_valid;
    logic [c_EW-1:0] r_main;

    always_comb begin
        w_ok   = 1'b0;
        w_ctrl = c_ALU_NONE;
        w_in1  = rs1_data;
        w_in2  = rs2_data;
        case (opcode)
            c_OP_R, c_OP_I: begin
                w_ok = 1'b1;
                if (opcode == c_OP_I) begin
                    w_in2 = imm;
                end
                case (funct3)
                    3'b000: w_ctrl = (opcode == c_OP_R && funct7b5) ? c_ALU_SUB : c_ALU_ADD;
                    3'b111: w_ctrl = c_ALU_AND;
                    3'b110: w_ctrl = c_ALU_OR;
                    3'b001: begin
                        w_ctrl = c_ALU_SLL;
                        if (opcode == c_OP_I) begin
                            w_in2 = {{(XLEN-5){1'b0}}, imm[4:0]};
                        end
                    end
                    3'b101: begin
                        w_ctrl = funct7b5 ? c_ALU_SRA : c_ALU_SRL;
                        if (opcode == c_OP_I) begin
                            w_in2 = {{(XLEN-5){1'b0}}, imm[4:0]};
                        end
                    end
                    default: w_ok = 1'b0;
                endcase
            end
            c_OP_LOAD, c_OP_STORE, c_OP_JALR: begin
                w_ok   = 1'b1;
                w_ctrl = c_ALU_ADD;
                w_in2  = imm;
            end
            c_OP_BRANCH: begin
                w_ok = 1'b1;
                case (funct3)
                    3'b000:  w_ctrl = c_ALU_BEQ;
                    3'b001:  w_ctrl = c_ALU_BNE;
                    3'b100:  w_ctrl = c_ALU_BLT;
                    3'b101:  w_ctrl = c_ALU_BGE;
                    default: w_ok   = 1'b0;
                endcase
            end
            c_OP_JAL: begin
                w_ok  = 1'b1;
                w_in1 = pc;
                w_in2 = imm;
            end
            default: w_ok = 1'b0;
        endcase
        // Undecodable instructions travel as a zeroed no-ALU entry.
        if (!w_ok) begin
            w_ctrl = c_ALU_NONE;
            w_in1  = '0;
            w_in2  = '0;
        end
    end

    assign w_dec     = {~w_ok, w_ctrl, (w_ok ? rd_in : 5'd0), w_in1, w_in2};
    assign w_in_xfer = in_valid & in_ready;

`ifdef ALU_ISSUE_SKID_EN
    logic            r_skid_valid;
    logic [c_EW-1:0] r_skid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main       <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || out_ready) begin
            // Skid is full only while ready is low, so it never races an input.
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_main       <= w_dec;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_xfer) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    assign in_ready = ~r_skid_valid;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
        end else if (!r_main_valid || out_ready) begin
            if (w_in_xfer) begin
                r_main       <= w_dec;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end
    end

    assign in_ready = ~r_main_valid | out_ready;
`endif

    assign out_valid = r_main_valid;
    assign illegal   = r_main[c_EW-1];
    assign alu_ctrl  = r_main[c_EW-2 -: 4];
    assign rd_out    = r_main[2*XLEN+4 -: 5];
    assign alu_in1   = r_main[2*XLEN-1 -: XLEN];
    assign alu_in2   = r_main[XLEN-1:0];

endmodule

`default_nettype wire
